serial_mag_comparator: RTL and testbench

- Bit-serial magnitude comparator sequencer for the ALU compare path.
- Latches two WIDTH-bit operands and feeds them MSB-first, one bit per clock, into the team's 1-bit cascade cell `comparator`.
- Holds the cell's cascade result (C1C0 <- Z1Z0) in a register between bits.
- Reports greater/less/equal with a start/done handshake.

---
 rtl/serial_mag_comparator_pkg.sv | 14 +
 rtl/comparator.sv | 18 +
 rtl/serial_mag_comparator.sv | 124 ++++++++++++
 tb/tb_serial_mag_comparator.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/serial_mag_comparator_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
package serial_mag_comparator_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Cascade seed: "no decision yet" going into the MSB
  localparam logic [1:0] CASCADE_SEED = 2'b00;

endpackage : serial_mag_comparator_pkg

// File: rtl/comparator.sv
// 1-bit cascade magnitude-compare cell, MSB-first.
// {c1,c0}: 10 = already greater, 01 = already less, 00 = equal so far.
module comparator (
  input  logic a,
  input  logic b,
  input  logic c1,
  input  logic c0,
  output logic z1,
  output logic z0
);

  // A decided cascade passes through; otherwise this bit decides
  always_comb begin
    z1 = c1 | (~c0 & a & ~b);
    z0 = c0 | (~c1 & ~a & b);
  end

endmodule : comparator

// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator with start/done handshake.
// Operands are latched on the accepting edge and fed MSB-first through
// the cascade cell, one bit per clock.
module serial_mag_comparator
  import serial_mag_comparator_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       cascade_q;
  logic             z1;
  logic             z0;
  logic             accept;
  logic             last_bit;
  logic             busy_d;
  logic             done_d;
  logic             gt_d;
  logic             lt_d;
  logic             eq_d;

  comparator u_cell (
    .a  (sa_q[WIDTH-1]),
    .b  (sb_q[WIDTH-1]),
    .c1 (cascade_q[1]),
    .c0 (cascade_q[0]),
    .z1 (z1),
    .z0 (z0)
  );

  assign accept   = (state_q != ST_SHIFT) && start;
  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; DONE behaves like IDLE so back-to-back starts are taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE,
      ST_DONE:  state_d = start ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: if (last_bit) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; flags clear on accept, set on last bit
  always_comb begin
    busy_d = (state_d == ST_SHIFT);
    done_d = last_bit;
    gt_d   = gt;
    lt_d   = lt;
    eq_d   = eq;
    if (accept) begin
      gt_d = 1'b0;
      lt_d = 1'b0;
      eq_d = 1'b0;
    end else if (last_bit) begin
      gt_d = z1;
      lt_d = z0;
      eq_d = ~z1 & ~z0;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      gt   <= 1'b0;
      lt   <= 1'b0;
      eq   <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      gt   <= gt_d;
      lt   <= lt_d;
      eq   <= eq_d;
    end
  end

  // Operand shifters, bit counter and cascade register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_q      <= '0;
      sb_q      <= '0;
      cnt_q     <= '0;
      cascade_q <= CASCADE_SEED;
    end else if (accept) begin
      sa_q      <= a;
      sb_q      <= b;
      cnt_q     <= '0;
      cascade_q <= CASCADE_SEED;
    end else if (state_q == ST_SHIFT) begin
      sa_q      <= sa_q << 1;
      sb_q      <= sb_q << 1;
      cnt_q     <= last_bit ? cnt_q : cnt_q + CNT_W'(1);
      cascade_q <= {z1, z0};
    end
  end

endmodule : serial_mag_comparator

// File: tb/tb_serial_mag_comparator.sv
// Self-checking bench for serial_mag_comparator (WIDTH=4 and WIDTH=8 instances).
module tb_serial_mag_comparator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, start8;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;
  logic       busy4, done4, gt4, lt4, eq4;
  logic       busy8, done8, gt8, lt8, eq8;
  logic       sel8;
  logic       busy_s, done_s, gt_s, lt_s, eq_s;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] exp_flags;  // {gt,lt,eq}
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  serial_mag_comparator #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .gt(gt4), .lt(lt4), .eq(eq4)
  );

  serial_mag_comparator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .gt(gt8), .lt(lt8), .eq(eq8)
  );

  assign busy_s = sel8 ? busy8 : busy4;
  assign done_s = sel8 ? done8 : done4;
  assign gt_s   = sel8 ? gt8   : gt4;
  assign lt_s   = sel8 ? lt8   : lt4;
  assign eq_s   = sel8 ? eq8   : eq4;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Flags must never be more than one-hot; cascade must never reach 11
  always @(negedge clk) begin
    chk("flags_exclusive4", 32'(gt4 + lt4 + eq4 > 1), 0);
    chk("flags_exclusive8", 32'(gt8 + lt8 + eq8 > 1), 0);
    chk("cascade_not11", 32'(dut4.cascade_q == 2'b11), 0);
  end

  // Reference model: plain unsigned comparison
  function automatic logic [2:0] ref_flags(input logic [7:0] a, input logic [7:0] b);
    return {a > b, a < b, a == b};
  endfunction

  // One compare on the selected DUT; returns flags, edges to done, busy cycles
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit watch_c00,
                        output logic [2:0] flags, output int lat, output int busy_n);
    @(negedge clk);
    if (sel8) begin a8 = a; b8 = b; start8 = 1'b1; end
    else begin a4 = a[3:0]; b4 = b[3:0]; start4 = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
    lat    = 0;
    busy_n = 0;
    while (!done_s && lat < 40) begin
      if (busy_s) busy_n++;
      if (watch_c00) chk("cascade_00", 32'(dut4.cascade_q), 0);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    flags = {gt_s, lt_s, eq_s};
  endtask

  initial begin
    logic [2:0] flags;
    int         lat, busy_n, dones;
    logic [7:0] ra, rb;

    vecs[0] = '{4'b1010, 4'b0110, 3'b100};
    vecs[1] = '{4'b0011, 4'b0101, 3'b010};
    vecs[2] = '{4'b1111, 4'b1111, 3'b001};
    vecs[3] = '{4'b0000, 4'b0000, 3'b001};
    vecs[4] = '{4'b0001, 4'b1000, 3'b010};
    vecs[5] = '{4'b0111, 4'b0110, 3'b100};

    sel8 = 1'b0; start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outs4", 32'({busy4, done4, gt4, lt4, eq4}), 0);
    chk("reset_outs8", 32'({busy8, done8, gt8, lt8, eq8}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs4", 32'({busy4, done4, gt4, lt4, eq4}), 0);

    // Table-driven WIDTH=4 vectors
    for (int i = 0; i < 6; i++) begin
      run_op({4'b0, vecs[i].a}, {4'b0, vecs[i].b}, vecs[i].exp_flags[0], flags, lat, busy_n);
      chk("vec_flags", 32'(flags), 32'(vecs[i].exp_flags));
      chk("vec_latency", 32'(lat), 4);
      chk("vec_busy_cycles", 32'(busy_n), 4);
      @(posedge clk);
      @(negedge clk);
      chk("vec_done_one_cycle", 32'(done4), 0);
      chk("vec_flags_held", 32'({gt4, lt4, eq4}), 32'(vecs[i].exp_flags));
    end

    // Start pulse and operand change during SHIFT are ignored
    @(negedge clk);
    a4 = 4'b1000; b4 = 4'b0111; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    start4 = 1'b1; a4 = 4'b0000;
    @(negedge clk);
    start4 = 1'b0;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done4) begin
        dones++;
        chk("ignore_flags", 32'({gt4, lt4, eq4}), 32'(3'b100));
      end
    end
    chk("ignore_one_done", 32'(dones), 1);

    // Back-to-back: start accepted in the DONE cycle
    run_op(8'h0A, 8'h06, 1'b0, flags, lat, busy_n);
    chk("b2b_first_flags", 32'(flags), 32'(3'b100));
    a4 = 4'b0001; b4 = 4'b0010; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    chk("b2b_flags_cleared", 32'({gt4, lt4, eq4}), 0);
    chk("b2b_busy_done", 32'({busy4, done4}), 32'(2'b10));
    repeat (3) @(negedge clk);
    chk("b2b_not_done_early", 32'(done4), 0);
    @(negedge clk);
    chk("b2b_second_done", 32'(done4), 1);
    chk("b2b_second_flags", 32'({gt4, lt4, eq4}), 32'(3'b010));

    // Asynchronous reset mid-SHIFT
    @(negedge clk);
    a4 = 4'b1100; b4 = 4'b0011; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_outs", 32'({busy4, done4, gt4, lt4, eq4}), 0);
    chk("rst_mid_state", 32'(dut4.state_q), 0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done4 || busy4) dones++;
    end
    chk("rst_no_done", 32'(dones), 0);

    // WIDTH=8 random pairs against the reference model
    sel8 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = (i % 8 == 0) ? ra : 8'($urandom);
      run_op(ra, rb, 1'b0, flags, lat, busy_n);
      chk("rand_flags", 32'(flags), 32'(ref_flags(ra, rb)));
      chk("rand_latency", 32'(lat), 8);
      chk("rand_busy_cycles", 32'(busy_n), 8);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_serial_mag_comparator
